// File: rtl/pipe_regs.sv
// Y86-64 pipeline state: F predicted PC, D/E/M/W stage registers and condition codes.
// Optional hazard/retire counters are built when PIPE_PERF_EN is defined.

module stage_reg #(
  parameter int         W   = 8,
  parameter logic [W-1:0] BUB = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Reset value and bubble value are the same state: an empty (nop) slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q <= BUB;
    else if (!stall) q <= bubble ? BUB : d;
  end
endmodule

module pipe_regs #(
  parameter int W_WORD = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     F_stall,
  input  logic                     D_stall,
  input  logic                     W_stall,
  input  logic                     D_bubble,
  input  logic                     E_bubble,
  input  logic                     M_bubble,
  input  logic                     set_cc,
  input  logic [W_WORD-1:0]        f_predPC,
  input  logic [20+2*W_WORD-1:0]   d_in,
  input  logic [28+3*W_WORD-1:0]   e_in,
  input  logic [17+2*W_WORD-1:0]   m_in,
  input  logic [16+2*W_WORD-1:0]   w_in,
  input  logic [2:0]               e_cc,
  output logic [W_WORD-1:0]        F_predPC,
  output logic [20+2*W_WORD-1:0]   D_q,
  output logic [28+3*W_WORD-1:0]   E_q,
  output logic [17+2*W_WORD-1:0]   M_q,
  output logic [16+2*W_WORD-1:0]   W_q,
  output logic [2:0]               CC,
  output logic                     ctrl_err
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]              perf_stall_d,
  output logic [31:0]              perf_bubble_e,
  output logic [31:0]              perf_retired
`endif
);
  localparam int D_W = 20 + 2*W_WORD;
  localparam int E_W = 28 + 3*W_WORD;
  localparam int M_W = 17 + 2*W_WORD;
  localparam int W_W = 16 + 2*W_WORD;

  localparam logic [3:0] STAT_AOK = 4'd1;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] RNONE    = 4'hF;

  // Bubble images: stat=AOK, icode=nop, ifun/cnd=0, register IDs=RNONE, data=0.
  localparam logic [D_W-1:0] D_BUB = {STAT_AOK, I_NOP, 4'h0, RNONE, RNONE, {(2*W_WORD){1'b0}}};
  localparam logic [E_W-1:0] E_BUB = {STAT_AOK, I_NOP, 4'h0, {(3*W_WORD){1'b0}},
                                      RNONE, RNONE, RNONE, RNONE};
  localparam logic [M_W-1:0] M_BUB = {STAT_AOK, I_NOP, 1'b0, {(2*W_WORD){1'b0}}, RNONE, RNONE};
  localparam logic [W_W-1:0] W_BUB = {STAT_AOK, I_NOP, {(2*W_WORD){1'b0}}, RNONE, RNONE};

  stage_reg #(.W(W_WORD), .BUB('0)) u_f (
    .clk(clk), .rst_n(rst_n), .stall(F_stall), .bubble(1'b0), .d(f_predPC), .q(F_predPC));

  // D_stall beats D_bubble inside stage_reg because stall is tested first.
  stage_reg #(.W(D_W), .BUB(D_BUB)) u_d (
    .clk(clk), .rst_n(rst_n), .stall(D_stall), .bubble(D_bubble), .d(d_in), .q(D_q));

  stage_reg #(.W(E_W), .BUB(E_BUB)) u_e (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .bubble(E_bubble), .d(e_in), .q(E_q));

  stage_reg #(.W(M_W), .BUB(M_BUB)) u_m (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .bubble(M_bubble), .d(m_in), .q(M_q));

  stage_reg #(.W(W_W), .BUB(W_BUB)) u_w (
    .clk(clk), .rst_n(rst_n), .stall(W_stall), .bubble(1'b0), .d(w_in), .q(W_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      CC <= 3'b100;
    else if (set_cc) CC <= e_cc;
  end

  // Sticky until reset so a transient control conflict is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   ctrl_err <= 1'b0;
    else if (D_stall && D_bubble) ctrl_err <= 1'b1;
  end

`ifdef PIPE_PERF_EN
  typedef struct packed {
    logic [3:0]        stat;
    logic [3:0]        icode;
    logic [W_WORD-1:0] val_e;
    logic [W_WORD-1:0] val_m;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
  } w_reg_t;

  w_reg_t w_view;
  logic   retire;

  assign w_view = w_in;
  assign retire = !W_stall && (w_view.stat == STAT_AOK) && (w_view.icode != I_NOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_d  <= '0;
      perf_bubble_e <= '0;
      perf_retired  <= '0;
    end else begin
      if (D_stall)  perf_stall_d  <= perf_stall_d + 32'd1;
      if (E_bubble) perf_bubble_e <= perf_bubble_e + 32'd1;
      if (retire)   perf_retired  <= perf_retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_regs.sv
module tb_pipe_regs;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         F_stall = 0, D_stall = 0, W_stall = 0;
  logic         D_bubble = 0, E_bubble = 0, M_bubble = 0, set_cc = 0;
  logic [63:0]  f_predPC = '0;
  logic [147:0] d_in = '0;
  logic [219:0] e_in = '0;
  logic [144:0] m_in = '0;
  logic [143:0] w_in = '0;
  logic [2:0]   e_cc = '0;
  logic [63:0]  F_predPC;
  logic [147:0] D_q;
  logic [219:0] E_q;
  logic [144:0] M_q;
  logic [143:0] W_q;
  logic [2:0]   CC;
  logic         ctrl_err;
`ifdef PIPE_PERF_EN
  logic [31:0]  perf_stall_d, perf_bubble_e, perf_retired;
`endif

  pipe_regs #(.W_WORD(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .set_cc(set_cc),
    .f_predPC(f_predPC), .d_in(d_in), .e_in(e_in), .m_in(m_in), .w_in(w_in), .e_cc(e_cc),
    .F_predPC(F_predPC), .D_q(D_q), .E_q(E_q), .M_q(M_q), .W_q(W_q), .CC(CC),
    .ctrl_err(ctrl_err)
`ifdef PIPE_PERF_EN
    , .perf_stall_d(perf_stall_d), .perf_bubble_e(perf_bubble_e), .perf_retired(perf_retired)
`endif
  );

  always #5 clk = ~clk;

  localparam int K_F = 0, K_D = 1, K_E = 2, K_M = 3, K_W = 4, K_CC = 5, K_ERR = 6;
  localparam int K_PSD = 7, K_PBE = 8, K_PRT = 9;

  localparam logic [147:0] D_BUB = {4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 128'h0};
  localparam logic [219:0] E_BUB = {4'h1, 4'h1, 4'h0, 192'h0, 16'hFFFF};
  localparam logic [144:0] M_BUB = {4'h1, 4'h1, 1'b0, 128'h0, 8'hFF};
  localparam logic [143:0] W_BUB = {4'h1, 4'h1, 128'h0, 8'hFF};

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  logic chk_tgl = 1'b0;
  int q_k[$];
  int q_c[$];
  logic [219:0] q_v[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [147:0] mk_d(input logic [3:0] st, ic, fn, ra, rb,
                                        input logic [63:0] vc, vp);
    return {st, ic, fn, ra, rb, vc, vp};
  endfunction
  function automatic logic [219:0] mk_e(input logic [3:0] st, ic, fn, input logic [63:0] vc, va, vb,
                                        input logic [3:0] de, dm, sa, sb);
    return {st, ic, fn, vc, va, vb, de, dm, sa, sb};
  endfunction
  function automatic logic [144:0] mk_m(input logic [3:0] st, ic, input logic cnd,
                                        input logic [63:0] ve, va, input logic [3:0] de, dm);
    return {st, ic, cnd, ve, va, de, dm};
  endfunction
  function automatic logic [143:0] mk_w(input logic [3:0] st, ic, input logic [63:0] ve, vm,
                                        input logic [3:0] de, dm);
    return {st, ic, ve, vm, de, dm};
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_F: return "F_predPC";  K_D: return "D_q";  K_E: return "E_q";  K_M: return "M_q";
      K_W: return "W_q";  K_CC: return "CC";  K_ERR: return "ctrl_err";
      K_PSD: return "perf_stall_d";  K_PBE: return "perf_bubble_e";  K_PRT: return "perf_retired";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [219:0] act(input int k);
    logic [219:0] r;
    r = '0;
    case (k)
      K_F:   r[63:0]  = F_predPC;
      K_D:   r[147:0] = D_q;
      K_E:   r        = E_q;
      K_M:   r[144:0] = M_q;
      K_W:   r[143:0] = W_q;
      K_CC:  r[2:0]   = CC;
      K_ERR: r[0]     = ctrl_err;
`ifdef PIPE_PERF_EN
      K_PSD: r[31:0]  = perf_stall_d;
      K_PBE: r[31:0]  = perf_bubble_e;
      K_PRT: r[31:0]  = perf_retired;
`endif
      default: r = '1;
    endcase
    return r;
  endfunction

  task automatic exp_next(input int k, input logic [219:0] v);
    q_k.push_back(k); q_c.push_back(cyc + 1); q_v.push_back(v);
  endtask
  task automatic exp_now(input int k, input logic [219:0] v);
    q_k.push_back(k); q_c.push_back(cyc); q_v.push_back(v);
  endtask

  task automatic ctl(input logic fs, ds, db, eb, mb, ws, scc);
    F_stall = fs; D_stall = ds; D_bubble = db; E_bubble = eb;
    M_bubble = mb; W_stall = ws; set_cc = scc;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    exp_now(K_F, 220'(64'h0));
    exp_now(K_D, 220'(D_BUB));
    exp_now(K_E, E_BUB);
    exp_now(K_M, 220'(M_BUB));
    exp_now(K_W, 220'(W_BUB));
    exp_now(K_CC, 220'(3'b100));
    exp_now(K_ERR, 220'(1'b0));
`ifdef PIPE_PERF_EN
    exp_now(K_PSD, 220'(32'h0));
    exp_now(K_PRT, 220'(32'h0));
`endif
    chk_tgl = ~chk_tgl;
    @(negedge clk);
    ctl(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    int c;
    logic [219:0] v;
    logic [219:0] a;
    forever begin
      @(posedge clk or chk_tgl);
      #1;
      while (q_c.size() > 0 && q_c[0] <= cyc) begin
        k = q_k.pop_front();
        c = q_c.pop_front();
        v = q_v.pop_front();
        a = act(k);
        n_vec++;
        if (a !== v) begin
          n_bad++;
          $display("FAIL %s (cycle %0d): got %h expected %h", kname(k), c, a, v);
        end
      end
    end
  end

  initial begin
    logic [147:0] dA, dB, dC, dD, dE, dF;
    logic [219:0] eA, eB, eD;
    logic [144:0] mA, mC, mD;
    logic [143:0] wA, wH;
    dA = mk_d(4'h1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h1234, 64'h000A);
    dB = mk_d(4'h1, 4'h2, 4'h0, 4'h1, 4'h3, 64'h0, 64'h000C);
    dC = mk_d(4'h1, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h000E);
    dD = mk_d(4'h1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0010);
    dE = mk_d(4'h1, 4'h5, 4'h0, 4'h7, 4'h4, 64'h8, 64'h0020);
    dF = mk_d(4'h1, 4'hB, 4'h0, 4'h6, 4'hF, 64'h0, 64'h0022);
    eA = mk_e(4'h1, 4'h3, 4'h0, 64'h55, 64'h0, 64'h0, 4'h2, 4'hF, 4'hF, 4'hF);
    eB = mk_e(4'h1, 4'h6, 4'h0, 64'h0, 64'h7, 64'h9, 4'h3, 4'hF, 4'h1, 4'h3);
    eD = mk_e(4'h1, 4'h7, 4'h1, 64'h40, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    mA = mk_m(4'h1, 4'h3, 1'b1, 64'h55, 64'h0, 4'h2, 4'hF);
    mC = mk_m(4'h1, 4'h5, 1'b1, 64'h100, 64'h0, 4'hF, 4'h6);
    mD = mk_m(4'h1, 4'h7, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF);
    wA = mk_w(4'h1, 4'h3, 64'h55, 64'h0, 4'h2, 4'hF);
    wH = mk_w(4'h2, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF);

    reset_pulse();

    n_vec++;
    if (D_q[143:140] !== 4'h1) begin
      n_bad++; $display("FAIL reset D_q.icode: got %h", D_q[143:140]);
    end
    n_vec++;
    if (E_q[11:8] !== 4'hF) begin
      n_bad++; $display("FAIL reset E_q.dstM: got %h", E_q[11:8]);
    end
    n_vec++;
    if (W_q[143:140] !== 4'h1) begin
      n_bad++; $display("FAIL reset W_q.stat: got %h", W_q[143:140]);
    end
    n_vec++;
    if (CC !== 3'b100) begin
      n_bad++; $display("FAIL reset CC: got %b", CC);
    end
    n_vec++;
    if (F_predPC !== 64'h0) begin
      n_bad++; $display("FAIL reset F_predPC: got %h", F_predPC);
    end

    f_predPC = 64'h100; d_in = dA; e_in = eA; m_in = mA; w_in = wA; e_cc = 3'b010;
    exp_next(K_F, 220'(64'h100));
    exp_next(K_D, 220'(dA));
    exp_next(K_E, eA);
    exp_next(K_M, 220'(mA));
    exp_next(K_W, 220'(wA));
    exp_next(K_CC, 220'(3'b100));

    @(negedge clk);
    ctl(0, 0, 0, 0, 0, 0, 1);
    f_predPC = 64'h200; d_in = dB; e_in = eB; e_cc = 3'b011;
    exp_next(K_F, 220'(64'h200));
    exp_next(K_D, 220'(dB));
    exp_next(K_E, eB);
    exp_next(K_CC, 220'(3'b011));

    @(negedge clk);
    ctl(1, 1, 0, 1, 0, 0, 0);
    f_predPC = 64'h300; d_in = dC; m_in = mC; e_cc = 3'b000;
    exp_next(K_F, 220'(64'h200));
    exp_next(K_D, 220'(dB));
    exp_next(K_E, E_BUB);
    exp_next(K_M, 220'(mC));
    exp_next(K_CC, 220'(3'b011));
    exp_next(K_ERR, 220'(1'b0));

    @(negedge clk);
    ctl(0, 0, 0, 0, 0, 0, 0);
    exp_next(K_D, 220'(dC));
    exp_next(K_F, 220'(64'h300));
    exp_next(K_E, eB);

    @(negedge clk);
    ctl(0, 0, 1, 1, 0, 0, 0);
    d_in = dD; e_in = eD; m_in = mD;
    exp_next(K_D, 220'(D_BUB));
    exp_next(K_E, E_BUB);
    exp_next(K_M, 220'(mD));

    @(negedge clk);
    ctl(0, 0, 0, 0, 1, 0, 0);
    exp_next(K_M, 220'(M_BUB));
    exp_next(K_E, eD);

    @(negedge clk);
    ctl(0, 0, 0, 0, 0, 0, 0);
    w_in = wH;
    exp_next(K_W, 220'(wH));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ctl(0, 0, 0, 0, 0, 1, 0);
      w_in = mk_w(4'h1, 4'h3, 64'(i + 1), 64'(i * 3), 4'(i), 4'hF);
      exp_next(K_W, 220'(wH));
    end
    reset_pulse();

    n_vec++;
    if (W_q[143:140] !== 4'h1) begin
      n_bad++; $display("FAIL halt reset W_q.stat: got %h", W_q[143:140]);
    end

    f_predPC = 64'h400; d_in = dE; w_in = wA;
    exp_next(K_D, 220'(dE));
    exp_next(K_F, 220'(64'h400));
    exp_next(K_W, 220'(wA));
    exp_next(K_ERR, 220'(1'b0));
    @(negedge clk);
    ctl(0, 1, 1, 0, 0, 0, 0);
    d_in = dF;
    exp_next(K_D, 220'(dE));
    exp_next(K_ERR, 220'(1'b1));
    @(negedge clk);
    ctl(0, 0, 0, 0, 0, 0, 0);
    exp_next(K_D, 220'(dF));
    exp_next(K_ERR, 220'(1'b1));
    @(negedge clk);
    exp_next(K_ERR, 220'(1'b1));
    reset_pulse();

    n_vec++;
    if (ctrl_err !== 1'b0) begin
      n_bad++; $display("FAIL reset ctrl_err: got %b", ctrl_err);
    end

`ifdef PIPE_PERF_EN
    w_in = W_BUB;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ctl(0, 1, 0, 0, 0, 0, 0);
    end
    exp_next(K_PSD, 220'(32'd3));
    exp_next(K_PRT, 220'(32'd0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ctl(0, 0, 0, 0, 0, 0, 0);
      w_in = mk_w(4'h1, (i == 3) ? 4'hB : 4'(3 + i), 64'(i), 64'h0, 4'h1, 4'hF);
    end
    exp_next(K_PRT, 220'(32'd4));
    exp_next(K_PSD, 220'(32'd3));
    exp_next(K_PBE, 220'(32'd0));
    @(negedge clk);
    w_in = mk_w(4'h2, 4'h3, 64'h0, 64'h0, 4'hF, 4'hF);
    @(negedge clk);
    w_in = W_BUB;
    @(negedge clk);
    ctl(0, 0, 0, 0, 0, 1, 0);
    w_in = wA;
    exp_next(K_PRT, 220'(32'd4));
    @(negedge clk);
    ctl(0, 0, 0, 0, 0, 0, 0);
    force dut.perf_bubble_e = 32'hFFFF_FFFF;
    #1;
    release dut.perf_bubble_e;
    E_bubble = 1'b1;
    exp_next(K_PBE, 220'(32'd0));
    @(negedge clk);
    ctl(0, 0, 0, 0, 0, 0, 0);
`endif

    for (int i = 0; i < 20 && q_c.size() > 0; i++) @(posedge clk);
    #2;
    while (q_c.size() > 0) begin
      n_bad++;
      $display("FAIL %s: expectation for cycle %0d never checked (timeout)",
               kname(q_k[0]), q_c[0]);
      void'(q_k.pop_front()); void'(q_c.pop_front()); void'(q_v.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
